rf_write_arbiter: RTL
=====================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter INIT_VALUE, default 16'h0000, value written to every register during a clear sweep.
REQ-002 Parameter CLEAR_ON_RESET, default 1; 1 = clear sweep after reset, 0 = enter RUN directly.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port clear  input  1  single-cycle request for a clear sweep of all eight registers.
REQ-006 Ports a_valid/a_ready  input/output  1/1  requester A handshake (ALU writeback).
REQ-007 Ports a_dr, a_data  input  3, 16  requester A destination register and write data.
REQ-008 Ports b_valid/b_ready  input/output  1/1  requester B handshake (memory load writeback).
REQ-009 Ports b_dr, b_data  input  3, 16  requester B destination register and write data.
REQ-010 Ports we, dr, wdata  output  1, 3, 16  register-file write port: WE, DR, bus.
REQ-011 Port init_done  output  1  high while in RUN; low during reset and any clear sweep.

Function
REQ-012 States: CLEAR and RUN only; encoding is free.
REQ-013 A transfer on a port occurs in a cycle where valid and ready are both 1.
REQ-014 a_ready = RUN & !clear & (!b_valid | last==B); b_ready = RUN & !clear & (!a_valid | last==A).
REQ-015 With both requesters valid in RUN, exactly one ready is 1: the one not granted most recently.
REQ-016 last is updated only on a transfer, to the granted requester; its reset value is B, so A wins the first contention.
REQ-017 ready outputs are combinational from state, clear, the other requester's valid, and last; never from a port's own valid.
REQ-018 On a transfer, at the next edge: we<=1, dr<=granted dr, wdata<=granted data (one-cycle latency).
REQ-019 In a RUN cycle without a transfer: we<=0, and dr/wdata hold their previous values.
REQ-020 Same DR on both ports in one cycle: only the granted write is issued; the other follows in a later cycle.
REQ-021 At most one write per cycle; a requester holds valid/dr/data stable until its transfer.
REQ-022 CLEAR sweep: 3-bit counter cnt from 0; each edge: we<=1, dr<=cnt, wdata<=INIT_VALUE, cnt<=cnt+1.
REQ-023 At the edge with cnt==7: state<=RUN, init_done<=1, cnt<=0; we is high for exactly 8 consecutive cycles.
REQ-024 clear=1 in RUN: no transfer that cycle; next edge state<=CLEAR, init_done<=0, cnt<=0, we<=0.
REQ-025 clear during CLEAR is ignored; the sweep is not restarted.
REQ-026 Both ready outputs are 0 in CLEAR regardless of valids.

Reset
REQ-027 On reset: we=0, dr=0, wdata=0, cnt=0, last=B, init_done=0.
REQ-028 After reset: state = CLEAR if CLEAR_ON_RESET=1, else RUN with init_done=1 at the first edge after reset deasserts.
REQ-029 Reset mid-sweep or mid-RUN aborts the current activity and restarts per REQ-028; no pending write is retained.

Verification
REQ-030 Reset release with CLEAR_ON_RESET=1 -> 8 cycles with we=1, dr=0..7, wdata=0000; then init_done=1 and we=0.
REQ-031 RUN, a_valid only, a_dr=3, a_data=1234 -> a_ready=1; next cycle we=1, dr=3, wdata=1234.
REQ-032 Both valid for 4 cycles (a: R1/AAAA, b: R2/BBBB, new data each transfer) -> grants alternate A,B,A,B; we=1 in each cycle after a grant.
REQ-033 Both valid with a_dr=b_dr=5, A=1111, B=2222, last=B -> write 1111 then 2222 in consecutive cycles.
REQ-034 clear pulse with a_valid=1 -> a_ready=0 that cycle; sweep writes INIT_VALUE to R0..R7; A is granted the cycle init_done rises.
REQ-035 reset asserted at sweep cycle 4 -> outputs return to reset values next edge; the sweep restarts from dr=0.

Source files
------------

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter
// Description : Two-requester write arbiter for an 8 x 16-bit register file.
//               Round-robin between ALU (A) and load (B) writebacks with a
//               registered single write port, plus a sweep that writes
//               INIT_VALUE into all eight registers after reset or on request.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_write_arbiter #(
  parameter logic [15:0] INIT_VALUE     = 16'h0000,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [2:0]  a_dr,
  input  logic [15:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [2:0]  b_dr,
  input  logic [15:0] b_data,
  output logic        we,
  output logic [2:0]  dr,
  output logic [15:0] wdata,
  output logic        init_done
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t      state;
  logic [2:0]  cnt;
  // 1 when A received the most recent grant, 0 when B did.
  logic        last_a;
  logic        a_fire;
  logic        b_fire;

  // Readiness depends only on state, clear, the other side's valid and the
  // last grant, so a requester never sees its own valid loop back.
  always_comb begin
    a_ready = (state == ST_RUN) & ~clear & (~b_valid | ~last_a);
    b_ready = (state == ST_RUN) & ~clear & (~a_valid |  last_a);
    a_fire  = a_valid & a_ready;
    b_fire  = b_valid & b_ready;
  end

  // Sweep / run sequencing and the registered register-file write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      we        <= 1'b0;
      dr        <= 3'd0;
      wdata     <= 16'h0000;
      cnt       <= 3'd0;
      last_a    <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          // clear is deliberately ignored here: the running sweep completes.
          we    <= 1'b1;
          dr    <= cnt;
          wdata <= INIT_VALUE;
          cnt   <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
            cnt       <= 3'd0;
          end
        end
        default: begin
          init_done <= 1'b1;
          if (clear) begin
            state     <= ST_CLEAR;
            init_done <= 1'b0;
            cnt       <= 3'd0;
            we        <= 1'b0;
          end else if (a_fire) begin
            we     <= 1'b1;
            dr     <= a_dr;
            wdata  <= a_data;
            last_a <= 1'b1;
          end else if (b_fire) begin
            we     <= 1'b1;
            dr     <= b_dr;
            wdata  <= b_data;
            last_a <= 1'b0;
          end else begin
            // Idle cycle: drop the strobe, leave dr/wdata as they were.
            we <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire
